// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared access-size codes, FSM state type and byte-merge helper
//          for the dual-lane data memory.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_t;

    // Overlay the enabled bytes of new_w onto old_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane_align
// Brief  : Per-lane combinational helper: byte enables, store replication,
//          alignment check and load extract/extend.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic        o_misalign,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

    // Alignment check, byte enables and replicated store data
    always_comb begin
        o_misalign  = 1'b0;
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_misalign  = i_addr_lo[0];
                o_be        = 4'b0011 << i_addr_lo;
                o_wdata_rep = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                o_misalign  = (i_addr_lo != 2'b00);
                o_be        = 4'b1111;
            end
            default: begin
                o_misalign  = 1'b1;
            end
        endcase
        if (o_misalign) begin
            o_be = 4'b0000;
        end
    end

    // Load result: selected field shifted to bit 0 and extended
    always_comb begin
        o_ldata = 32'h0;
        case (i_size)
            SZ_BYTE: o_ldata = i_unsigned ? {24'h0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: o_ldata = i_unsigned ? {16'h0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            SZ_WORD: o_ldata = i_rword;
            default: o_ldata = 32'h0;
        endcase
        if (o_misalign) begin
            o_ldata = 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dual_port_data_memory.sv
`default_nettype none
// ============================================================================
// Module : dual_port_data_memory
// Brief  : Two-lane byte/half/word data memory with registered reads,
//          program-order same-cycle resolution (lane 0 older) and a
//          post-reset clear sequence.
// Rev    : 1.0  initial release
// ============================================================================
module dual_port_data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  we,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [1:0]  unsigned_ld,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [1:0]  rvalid,
    output logic [1:0]  misalign
);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam dmem_state_t c_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [31:0]      r_mem [DEPTH];
    dmem_state_t      r_state;
    dmem_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic             w_clr_en;

    logic [IDX_W-1:0] w_idx0, w_idx1;
    logic             w_same;
    logic             w_act0, w_act1;
    logic             w_wr0, w_wr1;
    logic [3:0]       w_be0, w_be1;
    logic [31:0]      w_rep0, w_rep1;
    logic             w_mis0, w_mis1;
    logic [31:0]      w_ld0, w_ld1;
    logic [31:0]      w_old0, w_old1;
    logic [31:0]      w_st0_word, w_base1, w_st1_word;
    logic             w_unused_addr;

    assign w_idx0 = addr0[IDX_W+1:2];
    assign w_idx1 = addr1[IDX_W+1:2];
    assign w_same = (w_idx0 == w_idx1);

    // Upper address bits are deliberately ignored so accesses wrap
    assign w_unused_addr = ^{addr0[31:IDX_W+2], addr1[31:IDX_W+2]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave CLEAR once the last word has been zeroed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    // FSM outputs; ready is forced low while reset is held
    always_comb begin
        ready    = (r_state == ST_READY) && !reset;
        w_clr_en = (r_state == ST_CLEAR) && !reset;
    end

    // Clear counter walks every word index once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_clr_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    dmem_lane_align u_align0 (
        .i_size      (size0),
        .i_addr_lo   (addr0[1:0]),
        .i_unsigned  (unsigned_ld[0]),
        .i_wdata     (wdata0),
        .i_rword     (w_old0),
        .o_be        (w_be0),
        .o_wdata_rep (w_rep0),
        .o_misalign  (w_mis0),
        .o_ldata     (w_ld0)
    );

    dmem_lane_align u_align1 (
        .i_size      (size1),
        .i_addr_lo   (addr1[1:0]),
        .i_unsigned  (unsigned_ld[1]),
        .i_wdata     (wdata1),
        .i_rword     (w_base1),
        .o_be        (w_be1),
        .o_wdata_rep (w_rep1),
        .o_misalign  (w_mis1),
        .o_ldata     (w_ld1)
    );

    assign w_act0 = req_valid[0] && ready;
    assign w_act1 = req_valid[1] && ready;
    assign w_wr0  = w_act0 && we[0] && !w_mis0;
    assign w_wr1  = w_act1 && we[1] && !w_mis1;

    assign w_old0 = r_mem[w_idx0];
    assign w_old1 = r_mem[w_idx1];

    // Lane 1 is younger: it observes lane 0's store to the same word, and its
    // own store is layered on top so it wins overlapping bytes.
    assign w_st0_word = merge_bytes(w_old0, w_rep0, w_be0);
    assign w_base1    = (w_wr0 && w_same) ? w_st0_word : w_old1;
    assign w_st1_word = merge_bytes(w_base1, w_rep1, w_be1);

    // Storage: clear sweep, or lane commits (lane 1 word already holds lane 0 bytes)
    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[r_cnt] <= 32'h0;
        end else begin
            if (w_wr1) begin
                r_mem[w_idx1] <= w_st1_word;
            end
            if (w_wr0 && !(w_wr1 && w_same)) begin
                r_mem[w_idx0] <= w_st0_word;
            end
        end
    end

    // Response registers: stores and illegal requests return zero data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid   <= 2'b00;
            misalign <= 2'b00;
            rdata0   <= 32'h0;
            rdata1   <= 32'h0;
        end else begin
            rvalid   <= {w_act1, w_act0};
            misalign <= {w_act1 && w_mis1, w_act0 && w_mis0};
            rdata0   <= (w_act0 && !we[0]) ? w_ld0 : 32'h0;
            rdata1   <= (w_act1 && !we[1]) ? w_ld1 : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: doc/dual_port_data_memory.md
Name: dual_port_data_memory

Overview:
Two-lane data memory for the dual-issue pipeline. Lane 0 and lane 1 each issue one load or store per cycle. The block supports byte, half and word access with sign/zero extension and a 1-cycle registered read. Same-cycle lane conflicts are resolved in program order, with lane 0 older than lane 1. After reset, a clear state machine zeroes the memory before the block accepts any request.

Parameters:
DEPTH, 64, number of 32-bit words; must be a power of two, at least 2.
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the clear (contents undefined).
IDX_W, $clog2(DEPTH), localparam; word-index width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
ready  out  1  high when requests are accepted; low during reset and clear.
req_valid[1:0]  in  2  per-lane request strobe.
we[1:0]  in  2  per-lane write (1) / load (0).
size0, size1  in  2 each  00 byte, 01 half, 10 word, 11 reserved.
unsigned_ld[1:0]  in  2  per-lane zero-extend loads (1) / sign-extend (0).
addr0, addr1  in  32 each  byte address.
wdata0, wdata1  in  32 each  store data, right-aligned.
rdata0, rdata1  out  32 each  load result, extended, registered.
rvalid[1:0]  out  2  per-lane result valid, one cycle after the request.
misalign[1:0]  out  2  per-lane error pulse, coincident with rvalid.

Behaviour:
- Reset (async):
  - ready=0, rvalid=0, misalign=0, rdata0=rdata1=0, clear counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else to READY.
- FSM states:
  - CLEAR: write 0 to word[cnt] each cycle and increment cnt. When cnt==DEPTH-1 is written, go to READY. Clear takes DEPTH cycles. ready=0 throughout and all requests are ignored (no rvalid).
  - READY: ready=1. Stays here until reset. Reset asserted mid-clear restarts at cnt=0.
- Indexing: word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Alignment:
  - Half requires addr[0]=0. Word requires addr[1:0]=0. Size 11 is always illegal.
  - An illegal request performs no write, returns rdata=0 and sets rvalid=1, misalign=1 on the next cycle.
- Store:
  - Byte lanes are selected by addr[1:0] and size, with wdata replicated to the selected bytes.
  - Write commits at posedge. rvalid=1 and rdata=0 next cycle (stores acknowledge).
- Load:
  - rdata is registered one cycle after the request.
  - The selected byte or half is shifted to bit 0, then sign- or zero-extended per unsigned_ld. A word load ignores unsigned_ld.
- Same-cycle ordering (same word index):
  - Lane 0 store + lane 1 load: lane 1 sees the merged data (lane 0 stored bytes over old bytes).
  - Lane 0 load + lane 1 store: lane 0 sees the old data.
  - Both store: byte-wise merge, with lane 1 winning on overlapping bytes.
  - Both load: both see the same old word.
  - Different word indices never interact.
- A misaligned lane participates in no forwarding or merge.
- rvalid[i] = registered (req_valid[i] & ready). It is independent per lane; there is no backpressure.

Decomposition:
- Package dmem_pkg holds SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD localparams and the FSM state enum (ST_CLEAR, ST_READY).
- Sub-module dmem_lane_align, instantiated once per lane and purely combinational, computes:
  - byte-enable generation,
  - store-data replication,
  - the misalign flag,
  - load extract/extend from a 32-bit word.
- The top level holds the array, the FSM/counter, the same-cycle merge/forward logic and the output registers.

Test Plan:
- Clear: reset 1 cycle with DEPTH=64 → ready rises exactly 64 cycles after reset falls; word loads of 0x00, 0xFC return 0x00000000.
- Byte/half extension:
  - Store word 0x80FF7F01 to 0x10.
  - lb 0x11 → 0x0000007F; lb 0x12 → 0xFFFFFFFF; lbu 0x13 → 0x00000080; lh 0x12 → 0xFFFF80FF; lhu 0x12 → 0x000080FF.
- Same-cycle forwarding:
  - Initialise word at 0x20 to 0xAAAAAAAA.
  - Lane 0 sb 0x21=0x55 with lane 1 lw 0x20 → rdata1=0xAAAA55AA.
  - Swapped (lane 0 lw, lane 1 sb) → rdata0=0xAAAAAAAA.
- Dual store conflict: lane 0 sw 0x30=0x11223344, lane 1 sh 0x30=0xBEEF same cycle → later lw 0x30 = 0x1122BEEF.
- Misalign and wrap:
  - lh 0x41 and lw 0x42 → misalign=1, rdata=0, memory unchanged.
  - With DEPTH=64, sw 0x100=0xDEADBEEF then lw 0x000 → 0xDEADBEEF.
- Reset mid-operation: assert reset while rvalid is pending and mid-clear → rvalid=0 immediately; clear restarts and ready returns after a full 64 cycles.
